// File: rtl/tape_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tape_stream_fifo
//  Description : Parametrised tape byte FIFO with FWFT or registered-read
//                output, fill level, almost-full/almost-empty thresholds and
//                sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tape_stream_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter bit FWFT          = 1'b1,
  parameter int AFULL_LEVEL   = (1 << ADDRESS_WIDTH) - 16,
  parameter int AEMPTY_LEVEL  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  d,
  input  logic                   write,
  input  logic                   read,
  output logic [DATA_WIDTH-1:0]  q,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ADDRESS_WIDTH:0] level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clear_flags
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  localparam logic [ADDRESS_WIDTH:0]   c_depth   = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   c_afull   = (ADDRESS_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDRESS_WIDTH:0]   c_aempty  = (ADDRESS_WIDTH+1)'(AEMPTY_LEVEL);
  localparam logic [ADDRESS_WIDTH:0]   c_lvl_one = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] c_ptr_one = ADDRESS_WIDTH'(1);

  // Storage and shared bookkeeping
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH:0]   level_q, level_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;

  // Handshake decode; empty_w and q_w come from the selected read path
  logic                     empty_w;
  logic [DATA_WIDTH-1:0]    q_w;
  logic                     full_w;
  logic                     rd_ok;
  logic                     wr_ok;

  assign full_w = (level_q == c_depth);
  assign rd_ok  = read & ~empty_w;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign wr_ok  = write & (~full_w | rd_ok);

  // Next-state for the write pointer, fill level and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end

    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + c_lvl_one;
      2'b01:   level_d = level_q - c_lvl_one;
      default: level_d = level_q;
    endcase

    // A fresh event in the same cycle as clear_flags keeps the flag set.
    if (clear_flags) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write & ~wr_ok) begin
      overflow_d = 1'b1;
    end
    if (read & empty_w) begin
      underflow_d = 1'b1;
    end
  end

  // Register the shared bookkeeping state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // RAM write port; contents need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr_q] <= d;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Two-stage prefetch: RAM output stage (mid) feeds the head register.
      logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
      logic                     mid_valid_q, mid_valid_d;
      logic                     head_valid_q, head_valid_d;
      logic [DATA_WIDTH-1:0]    head_q, head_d;
      logic [DATA_WIDTH-1:0]    ram_rd_q;
      logic [ADDRESS_WIDTH:0]   ram_count;
      logic                     head_load;
      logic                     fetch;

      assign empty_w = ~head_valid_q;
      assign q_w     = head_q;

      // Decide when to pull the next word out of RAM and advance the head.
      always_comb begin
        // Words still sitting in RAM, not yet in the mid or head stage.
        ram_count = level_q
                  - {{ADDRESS_WIDTH{1'b0}}, head_valid_q}
                  - {{ADDRESS_WIDTH{1'b0}}, mid_valid_q};
        // Head takes the mid word when it is empty or being popped.
        head_load = mid_valid_q & (~head_valid_q | rd_ok);
        // Fetch only when the mid stage is free or draining this cycle.
        fetch     = (ram_count != '0) & (~mid_valid_q | head_load);

        rd_ptr_d     = rd_ptr_q;
        mid_valid_d  = mid_valid_q;
        head_valid_d = head_valid_q;
        head_d       = head_q;

        if (fetch) begin
          rd_ptr_d    = rd_ptr_q + c_ptr_one;
          mid_valid_d = 1'b1;
        end else if (head_load) begin
          mid_valid_d = 1'b0;
        end

        if (head_load) begin
          head_d       = ram_rd_q;
          head_valid_d = 1'b1;
        end else if (rd_ok) begin
          head_valid_d = 1'b0;
        end
      end

      // Synchronous RAM read port feeding the mid stage.
      always_ff @(posedge clk) begin
        if (fetch) begin
          ram_rd_q <= mem[rd_ptr_q];
        end
      end

      // Register the prefetch pipeline state.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_ptr_q     <= '0;
          mid_valid_q  <= 1'b0;
          head_valid_q <= 1'b0;
          head_q       <= '0;
        end else begin
          rd_ptr_q     <= rd_ptr_d;
          mid_valid_q  <= mid_valid_d;
          head_valid_q <= head_valid_d;
          head_q       <= head_d;
        end
      end
    end else begin : g_regread
      // Registered read: q loads on the edge that accepts the pop.
      logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
      logic [DATA_WIDTH-1:0]    dout_q;

      assign empty_w = (level_q == '0);
      assign q_w     = dout_q;

      // Read pointer advances once per accepted pop.
      always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rd_ok) begin
          rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
      end

      // Read pointer and RAM read port into the output register.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_ptr_q <= '0;
          dout_q   <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_d;
          if (rd_ok) begin
            dout_q <= mem[rd_ptr_q];
          end
        end
      end
    end
  endgenerate

  assign q            = q_w;
  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_full  = (level_q >= c_afull);
  assign almost_empty = (level_q <= c_aempty);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: doc/tape_stream_fifo.md
# tape_stream_fifo

Parametrised successor to the single-width hyperload FIFO that buffers tape bytes from the control module ahead of the machine's tape path. It provides a configurable data width and depth, a selectable first-word-fall-through (FWFT) or registered-read mode, and a fill-level output. Programmable almost-full and almost-empty thresholds let the producer throttle before overflow. Sticky overflow and underflow flags let firmware detect lost or phantom bytes. It sits in the 50 MHz domain, between the control module's tape data strobe and the tape replay logic.

## Interface
- DATA_WIDTH, 8, word width in bits.
- ADDRESS_WIDTH, 9, log2 of depth; DEPTH = 2^ADDRESS_WIDTH.
- FWFT, 1, 1 = first-word-fall-through; 0 = registered read.
- AFULL_LEVEL, DEPTH-16, almost_full threshold; legal range 1..DEPTH.
- AEMPTY_LEVEL, 16, almost_empty threshold; legal range 0..DEPTH-1.
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; flushes the FIFO and clears all flags.
- d  in  DATA_WIDTH  write data.
- write  in  1  write request, one word per cycle while high.
- read  in  1  read request / pop.
- q  out  DATA_WIDTH  read data.
- empty  out  1  no valid word is presented or available.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AFULL_LEVEL.
- almost_empty  out  1  level <= AEMPTY_LEVEL.
- level  out  ADDRESS_WIDTH+1  words accepted and not yet popped.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was ignored.
- clear_flags  in  1  clears overflow and underflow on the next edge.

## Operation
- Storage is a DEPTH x DATA_WIDTH synchronous-read RAM plus ADDRESS_WIDTH-bit write and read pointers.
- Pointers wrap naturally from DEPTH-1 to 0.
- rd_ok = read & !empty.
- wr_ok = write & (!full | rd_ok). A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- A write with !wr_ok is dropped and sets overflow.
- A read with empty=1 is ignored and sets underflow. This holds even if a write is accepted in the same cycle.
- level update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- full, almost_full and almost_empty are combinational decodes of the level register.
- FWFT=1:
  - An output register holds the head word; empty = !head_valid.
  - When head_valid is 0 and data is in the RAM, the block fetches it automatically.
  - rd_ok pops the head. If more data remains, the next word appears on q without a bubble.
- FWFT=0:
  - empty = (level == 0).
  - On rd_ok, q is loaded at that edge with the word at the read pointer.
  - q holds its value until the next rd_ok.
- clear_flags and a new overflow/underflow event in the same cycle: the new event wins, so the flag stays 1.
- reset overrides write, read and clear_flags in the same cycle. Contents are discarded mid-stream and no flags are set.

## Timing
- Reset values (after the reset edge):
  - level = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0, q = 0, both pointers = 0.
- Write latency, FWFT=1, FIFO empty:
  - Write accepted at edge N gives level = 1 after edge N.
  - q valid and empty = 0 after edge N+2 (RAM read, then head register load).
  - level may therefore be nonzero while empty = 1, for at most 2 cycles.
- Write latency, FWFT=0: empty = 0 after edge N.
- Read latency, FWFT=0: read at edge M gives q valid after edge M (q is registered).
- Back-to-back streaming, FWFT=1 with continuous read: one word per cycle, no bubbles once the head is valid.
- level, full and the almost flags change after the same edge as the pointer update. There is no extra lag.
- Sticky flags set after the edge of the offending request.

## Test plan
- Reset, then write 0x01..0x05 on consecutive cycles, FWFT=1, default params:
  - empty falls 2 cycles after the first write, and q = 0x01.
  - Continuous read then returns 0x01..0x05 on consecutive cycles, and empty rises after the 5th pop.
- Fill to 512 words:
  - full = 1, level = 512.
  - One extra write sets overflow, and level stays 512.
  - Simultaneous read+write while full keeps level at 512, sets no flag, and preserves data order.
- Read on an empty FIFO sets underflow = 1 and leaves q unchanged.
  - clear_flags for one cycle returns underflow to 0.
  - clear_flags held while another empty read occurs keeps underflow at 1.
- Threshold sweep with AFULL_LEVEL=4 and AEMPTY_LEVEL=1:
  - almost_empty drops when level goes 1→2.
  - almost_full rises when level goes 3→4.
  - Both revert on the matching pops.
- Wrap-around with ADDRESS_WIDTH=3, FWFT=0: push/pop 20 incrementing bytes with random gaps.
  - Every q matches the scoreboard.
  - read returns each word on the same edge it is accepted.
- reset asserted with level = 7 while write and read are both high: after the edge, level = 0, empty = 1, and no flags are set.
